// File: rtl/i2c_master_seq.sv
// i2c_master_seq: byte-level I2C master sequencer (START/WRITE/READ/STOP)
// driving open-drain SCL/SDA tristate controls with clock stretching support.
module i2c_master_seq #(
    parameter int CLKS_PER_QTR = 98
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_t,
    output logic       sda_t,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam int W = $clog2(CLKS_PER_QTR);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_QTR - 1);
    localparam logic [1:0] OP_START = 2'b00, OP_WRITE = 2'b01, OP_STOP = 2'b11;

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic [1:0]   qtr;
    logic [3:0]   bitn;
    logic [7:0]   sh;
    logic         wr, ack, bus_owned, stretch, qend, nxt_out;

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign stretch   = scl_t & ~scl_i;
    assign qend      = cnt == LAST;
    // sh has already shifted once per sampled bit, so sh[7] is the next bit to send
    assign nxt_out   = bitn == 4'd7 ? (wr ? 1'b1 : ack) : (wr ? sh[7] : 1'b1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            qtr       <= '0;
            bitn      <= '0;
            sh        <= '0;
            wr        <= 1'b0;
            ack       <= 1'b0;
            bus_owned <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
            scl_t     <= 1'b1;
            sda_t     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE) begin
                cnt  <= '0;
                qtr  <= '0;
                bitn <= '0;
                if (cmd_valid) begin
                    wr  <= cmd_op == OP_WRITE;
                    sh  <= cmd_data;
                    ack <= cmd_ack;
                    if (cmd_op == OP_START) begin
                        state     <= START;
                        sda_t     <= 1'b1;
                        bus_owned <= 1'b1;
                    end else if (cmd_op == OP_STOP) begin
                        if (bus_owned) begin
                            state <= STOP;
                            scl_t <= 1'b0;
                            sda_t <= 1'b0;
                        end
                    end else if (!bus_owned) begin
                        rsp_valid <= 1'b1;
                        rsp_nack  <= 1'b1;
                        rsp_data  <= 8'hFF;
                    end else begin
                        state <= BIT;
                        scl_t <= 1'b0;
                        sda_t <= cmd_op == OP_WRITE ? cmd_data[7] : 1'b1;
                    end
                end
            end else if (!stretch) begin
                cnt <= qend ? '0 : cnt + 1'b1;
                if (qend) begin
                    qtr <= qtr + 2'd1;
                    if (state == BIT) begin
                        scl_t <= qtr == 2'd0 ? 1'b1 : qtr == 2'd1 ? scl_t : 1'b0;
                        if (qtr == 2'd1) begin
                            if (bitn == 4'd8)
                                ack <= wr ? sda_i : ack;
                            else
                                sh <= {sh[6:0], sda_i};
                        end
                        if (qtr == 2'd3) begin
                            bitn  <= bitn + 4'd1;
                            sda_t <= bitn == 4'd8 ? sda_t : nxt_out;
                            if (bitn == 4'd8) begin
                                state     <= IDLE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= wr ? 8'hFF : sh;
                                rsp_nack  <= ack;
                            end
                        end
                    end else if (state == START) begin
                        scl_t <= qtr == 2'd0 ? 1'b1 : qtr == 2'd2 ? 1'b0 : scl_t;
                        sda_t <= qtr == 2'd1 ? 1'b0 : sda_t;
                        if (qtr == 2'd3)
                            state <= IDLE;
                    end else begin
                        scl_t <= qtr == 2'd0 ? 1'b1 : scl_t;
                        sda_t <= qtr == 2'd2 ? 1'b1 : sda_t;
                        if (qtr == 2'd3) begin
                            state     <= IDLE;
                            bus_owned <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: directed bench for i2c_master_seq with an open-drain
// responder model and a response scoreboard.
module tb_i2c_master_seq;
    localparam int Q = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_ack, rsp_valid, rsp_nack, busy;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, rsp_data;
    logic       scl_t, sda_t, scl_i, sda_i;

    always #5 clk = ~clk;

    i2c_master_seq #(.CLKS_PER_QTR(Q)) dut (
        .CLK(clk), .RST(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .busy(busy), .scl_t(scl_t), .sda_t(sda_t), .scl_i(scl_i), .sda_i(sda_i)
    );

    int vectors = 0, miscompares = 0, cyc = 0, acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder: presents pat MSB first, advancing on each SCL fall
    logic [8:0] pat = 9'h1FF;
    logic       hold = 1'b0, resp_sda;
    int         base = 0, falls = 0, bi;
    always_comb begin
        bi = falls - base;
        resp_sda = (bi >= 0 && bi <= 8) ? pat[8 - bi] : 1'b1;
    end
    assign scl_i = scl_t & ~hold;
    assign sda_i = sda_t & resp_sda;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       pscl = 1'b1, psda = 1'b1;
    logic [8:0] cap = '0, e;
    logic [8:0] expq[$];
    int         rises = 0, act = 0, start_cyc = -1, stop_cyc = -1, low8 = 0, rsp_cnt = 0, rsp_cyc = -1;

    always @(negedge clk) begin
        if (scl_t !== pscl || sda_t !== psda) act++;
        if (scl_t && !pscl) begin
            rises++;
            cap = {cap[7:0], sda_t};
        end
        if (!scl_t && pscl) falls++;
        if (scl_t && pscl && !sda_t && psda) start_cyc = cyc;
        if (scl_t && pscl && sda_t && !psda) stop_cyc = cyc;
        if (busy && bi == 8 && !sda_t) low8++;
        pscl = scl_t;
        psda = sda_t;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (expq.size() == 0)
                chk("rsp_unexpected", 1, 0);
            else begin
                e = expq.pop_front();
                chk("rsp_data", rsp_data, e[8:1]);
                chk("rsp_nack", rsp_nack, e[0]);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic a);
        int n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        base = falls;
        cmd_op = op;
        cmd_data = d;
        cmd_ack = a;
        cmd_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        chk({tag, "_busy"}, busy, 1);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, cyc - acc, lat);
        #1;
    endtask

    initial begin
        int r0, a0, l0, n;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 8'h00;
        cmd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl_t, 1);
        chk("rst_sda", sda_t, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_nack", rsp_nack, 0);
        rst = 1'b0;
        @(negedge clk);

        send(2'b00, 8'h00, 1'b0);
        wait_done("start", 4 * Q + 1);
        chk("start_sda_fall", start_cyc, acc + 9);
        chk("start_scl_end", scl_t, 0);
        chk("start_sda_end", sda_t, 0);

        pat = 9'h1FE;
        r0 = rises;
        expq.push_back({8'hFF, 1'b0});
        send(2'b01, 8'hA5, 1'b0);
        wait_done("write", 36 * Q + 1);
        chk("write_pulses", rises - r0, 9);
        chk("write_bits", cap, 9'b1_0100_1011);
        chk("write_rsp_cyc", rsp_cyc, acc + 145);

        pat = {8'h3C, 1'b1};
        l0 = low8;
        expq.push_back({8'h3C, 1'b1});
        send(2'b10, 8'h00, 1'b1);
        wait_done("read", 36 * Q + 1);
        chk("read_bit8_sda_low", low8 - l0, 0);
        chk("read_ack_slot", cap[0], 1);

        pat = {8'h96, 1'b1};
        expq.push_back({8'h96, 1'b0});
        send(2'b10, 8'h00, 1'b0);
        n = 0;
        while (!(bi == 3 && scl_t) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        hold = 1'b1;
        repeat (20) @(negedge clk);
        hold = 1'b0;
        wait_done("read_stretch", 36 * Q + 1 + 20);
        chk("read_ack_drive", cap[0], 0);

        send(2'b11, 8'h00, 1'b0);
        wait_done("stop", 4 * Q + 1);
        chk("stop_sda_rise", stop_cyc, acc + 13);
        chk("stop_scl_rel", scl_t, 1);
        chk("stop_sda_rel", sda_t, 1);

        a0 = act;
        r0 = rsp_cnt;
        expq.push_back({8'hFF, 1'b1});
        send(2'b01, 8'h12, 1'b0);
        #1;
        chk("err_rsp_cyc", rsp_cyc, acc + 1);
        chk("err_ready", cmd_ready, 1);
        send(2'b11, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("err_activity", act - a0, 0);
        chk("err_rsp_count", rsp_cnt - r0, 1);
        chk("stop_noop_ready", cmd_ready, 1);

        send(2'b00, 8'h00, 1'b0);
        wait_done("start2", 4 * Q + 1);
        pat = 9'h1FF;
        r0 = rsp_cnt;
        expq.push_back({8'hFF, 1'b1});
        send(2'b01, 8'h5A, 1'b0);
        n = 0;
        while (!(bi == 5 && scl_t) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("pre_rst_sda", sda_t, 0);
        rst = 1'b1;
        #1;
        chk("midrst_scl", scl_t, 1);
        chk("midrst_sda", sda_t, 1);
        chk("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        repeat (60) @(negedge clk);
        #1;
        chk("midrst_no_rsp", rsp_cnt - r0, 0);

        send(2'b00, 8'h00, 1'b0);
        wait_done("start3", 4 * Q + 1);
        chk("start3_sda_fall", start_cyc, acc + 9);
        chk("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
